mul_issue_ctrl: RTL

- Issue controller and round-robin arbiter that shares the two-stage signed 32x32 multiplier (Booth/Wallace stage 1 plus stage-2 register and final adder) between two requesters.
- Accepts requests on valid/ready ports and drives operands into the multiplier.
- Tracks each in-flight operation through the multiplier's fixed latency, selects the low or high product word, and buffers results in a small FIFO so the non-stallable multiplier never loses a result under backpressure.
- Sits between the execute-stage issue logic and the multiplier.

---
 rtl/mul_issue_ctrl_pkg.sv | 12 +
 rtl/mul_resp_fifo.sv | 52 +++++
 rtl/mul_issue_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mul_issue_ctrl_pkg.sv
// Shared constants and in-flight entry layout for the multiplier issue controller.
package mul_issue_ctrl_pkg;
    localparam int MUL_LAT_DEF    = 1;
    localparam int TAG_W_DEF      = 4;
    localparam int OBUF_DEPTH_DEF = 2;
    localparam int DATA_W         = 32;

    // In-flight entry packs {hi, tag, src}: src at bit 0, tag above it, hi on top.
    function automatic int ent_w(input int tag_w);
        return tag_w + 2;
    endfunction
endpackage

// File: rtl/mul_resp_fifo.sv
// Small synchronous result FIFO with occupancy count and a synchronous clear.
module mul_resp_fifo #(
    parameter  int WIDTH = 37,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_resetn || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push)
            r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/mul_issue_ctrl.sv
// Round-robin issue controller sharing one pipelined multiplier between two requesters,
// with credit-based admission so the non-stallable multiplier never overruns the result FIFO.
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter int MUL_LAT    = MUL_LAT_DEF,
    parameter int TAG_W      = TAG_W_DEF,
    parameter int OBUF_DEPTH = OBUF_DEPTH_DEF
) (
    input  logic                     mul_clk,
    input  logic                     resetn,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic signed [31:0]       req0_a,
    input  logic signed [31:0]       req0_b,
    input  logic                     req0_hi,
    input  logic [TAG_W-1:0]         req0_tag,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic signed [31:0]       req1_a,
    input  logic signed [31:0]       req1_b,
    input  logic                     req1_hi,
    input  logic [TAG_W-1:0]         req1_tag,
    input  logic                     flush,
    output logic signed [31:0]       mul_x,
    output logic signed [31:0]       mul_y,
    input  logic signed [63:0]       mul_result,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_data,
    output logic [TAG_W-1:0]         resp_tag,
    output logic                     resp_src
);
    localparam int ENT_W = ent_w(TAG_W);
    localparam int FW    = DATA_W + TAG_W + 1;
    localparam int CNT_W = $clog2(OBUF_DEPTH + 1);

    logic [MUL_LAT-1:0] r_sr_vld;
    logic [ENT_W-1:0]   r_sr_ent [MUL_LAT];
    logic               r_rr_last;

    logic               w_can_issue;
    logic               w_grant0;
    logic               w_grant1;
    logic [31:0]        w_occ;
    logic [CNT_W-1:0]   w_fifo_cnt;
    logic               w_fifo_push;
    logic               w_fifo_pop;
    logic [ENT_W-1:0]   w_issue_ent;
    logic [ENT_W-1:0]   w_last_ent;
    logic [FW-1:0]      w_push_data;
    logic [FW-1:0]      w_head;

    function automatic logic [DATA_W-1:0] sel_word(input logic signed [63:0] prod, input logic hi);
        return hi ? prod[63:32] : prod[31:0];
    endfunction

    // Credit counts in-flight stages plus buffered results; a same-cycle pop frees nothing yet.
    always_comb begin
        w_occ = 32'(w_fifo_cnt);
        for (int i = 0; i < MUL_LAT; i++)
            w_occ = w_occ + 32'(r_sr_vld[i]);
    end

    assign w_can_issue = resetn && !flush && (w_occ < 32'(OBUF_DEPTH));
    assign w_grant0    = w_can_issue && req0_valid && (!req1_valid || r_rr_last);
    assign w_grant1    = w_can_issue && req1_valid && (!req0_valid || !r_rr_last);
    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;

    assign mul_x       = w_grant0 ? req0_a : (w_grant1 ? req1_a : '0);
    assign mul_y       = w_grant0 ? req0_b : (w_grant1 ? req1_b : '0);
    assign w_issue_ent = w_grant0 ? {req0_hi, req0_tag, 1'b0} : {req1_hi, req1_tag, 1'b1};

    always_ff @(posedge mul_clk) begin
        if (!resetn)
            r_rr_last <= 1'b1;
        else if (w_grant0)
            r_rr_last <= 1'b0;
        else if (w_grant1)
            r_rr_last <= 1'b1;
    end

    // Issue stage: track each op through the multiplier's fixed latency.
    always_ff @(posedge mul_clk) begin
        if (!resetn || flush) begin
            r_sr_vld <= '0;
        end else begin
            r_sr_vld[0] <= w_grant0 || w_grant1;
            for (int i = 1; i < MUL_LAT; i++)
                r_sr_vld[i] <= r_sr_vld[i-1];
        end
    end

    always_ff @(posedge mul_clk) begin
        r_sr_ent[0] <= w_issue_ent;
        for (int i = 1; i < MUL_LAT; i++)
            r_sr_ent[i] <= r_sr_ent[i-1];
    end

    // Capture stage: product word selected as the op leaves the multiplier.
    assign w_last_ent  = r_sr_ent[MUL_LAT-1];
    assign w_fifo_push = resetn && !flush && r_sr_vld[MUL_LAT-1];
    assign w_push_data = {sel_word(mul_result, w_last_ent[ENT_W-1]), w_last_ent[TAG_W:0]};

    assign resp_valid  = resetn && !flush && (w_fifo_cnt != '0);
    assign w_fifo_pop  = resp_valid && resp_ready;

    mul_resp_fifo #(
        .WIDTH (FW),
        .DEPTH (OBUF_DEPTH)
    ) u_fifo (
        .i_clk       (mul_clk),
        .i_resetn    (resetn),
        .i_clr       (flush),
        .i_push      (w_fifo_push),
        .i_push_data (w_push_data),
        .i_pop       (w_fifo_pop),
        .o_head      (w_head),
        .o_count     (w_fifo_cnt)
    );

    assign resp_data = w_head[FW-1 -: DATA_W];
    assign resp_tag  = w_head[TAG_W:1];
    assign resp_src  = w_head[0];
endmodule
